fin_sync: RTL and testbench
===========================

# fin_sync

Clock-domain capture stage placed directly downstream of the request-OR completion detector. Takes that detector's self-resetting `fin` pulse, which is asynchronous, may be narrower than a clock period, and carries no data. Converts each rising edge into a counted completion event in the `clk` domain, presented over a valid/ready handshake. Events arriving while the consumer stalls are coalesced into a saturating count, with a sticky overflow flag.

## Interface
- `CNT_WIDTH`, default 4: width of event counts. Max count is 2^CNT_WIDTH-1.
- `SYNC_STAGES`, default 2: synchronizer depth. Legal range ≥2.
- `clk` in 1: single clock. All state except the capture toggle is updated on its rising edge.
- `rstn` in 1: reset, asynchronous, active-low. Clears every register, including the capture toggle.
- `fin` in 1: asynchronous completion pulse from the request-OR stage. Only its rising edge is significant.
- `evValid` out 1: an event count is presented.
- `evReady` in 1: consumer accepts the count on the cycle where `evValid && evReady`.
- `evCount` out CNT_WIDTH: number of `fin` edges represented by the current transfer. Always ≥1 while `evValid`.
- `overflow` out 1: sticky flag; at least one event was lost to saturation.
- `clrOverflow` in 1: synchronous clear of `overflow`.

## Operation
- **Capture:** `finTgl` toggles on every `posedge fin`. It is asynchronously cleared by `rstn`. Edges during reset are ignored.
- **Sync:** `finTgl` passes through `SYNC_STAGES` flops `s[0..S-1]`, then one history flop `p`.
  - `evt = s[S-1] ^ p`, giving one clk-cycle pulse per `fin` edge.
- **Accumulator:** `acc` holds events not yet loaded into the output register.
- **FSM states:**
  - **IDLE:** `evValid=0`. If `evt`:
    - load `evCount<=1`, `acc<=0`, next state VALID.
  - **VALID:** `evValid=1`. `evCount` is held stable until accepted. `evt` adds 1 to `acc`, saturating.
    - Accept with `acc+evt>0`: `evCount<=sat(acc+evt)`, `acc<=0`, stay VALID (back-to-back transfer, no bubble).
    - Accept with `acc+evt==0`: go to IDLE.
    - No accept: hold.
- **Saturation:**
  - `acc` stays at max.
  - Any `evt` that cannot be added sets `overflow<=1`.
  - A sum saturating during a load also sets `overflow`.
- **Overflow clear:** `clrOverflow` clears `overflow`. If a set and a clear occur in the same cycle, the set wins.
- **Input constraint:** successive `fin` rising edges must be ≥2 clk periods apart. Closer edges may cancel each other; this is not detected. There is no minimum `fin` pulse width beyond the toggle flop's own.

## Timing
- **Reset values:** `evValid=0`, `evCount=0`, `overflow=0`, state IDLE, `acc=0`, `finTgl=0`, all sync flops 0.
- **Latency:** `fin` edge before clk edge k (setup met) → `evt` high in the cycle after edge k+S-1 → `evValid` high after edge k+S.
  - Equals S+1 edges (3 for default), +1 edge under metastability.
- **Handshake:** acceptance is sampled at the rising edge.
  - `evValid` deasserts, or a new `evCount` appears, on the edge following an accept.
  - `evCount` never changes while `evValid && !evReady`.
- **Simultaneous evt and accept:** the event is included in the reload, never dropped.
- **Reset mid-operation:** `rstn` low clears everything immediately, including pending counts and any in-flight synchronizer state.
  - No event is emitted for edges captured before reset.
  - The first post-reset `fin` edge behaves normally.
- **Clocking:** `evReady` and `clrOverflow` are synchronous to `clk`.

## Test plan
- **Single event:** reset; one 3 ns `fin` pulse with 10 ns clk → `evValid` rises 3 edges later (4 allowed), `evCount=1`. With `evReady=1`, drops after 1 cycle; `overflow=0`.
- **Narrow pulse:** 1 ns `fin` pulse placed mid-cycle → still captured, `evCount=1`.
- **Coalescing under stall:** `evReady=0`; 4 pulses spaced 3 clk → first transfer `evCount=1` held stable. Raise `evReady` for one cycle → next cycle `evValid=1`, `evCount=3`; then IDLE.
- **Saturation:** `CNT_WIDTH=2`, stall; 6 pulses → `evCount=1`, then `evCount=3`, `overflow=1`. `clrOverflow` pulse → 0. With a concurrent overflow-causing event → stays 1.
- **Accept/evt collision:** `evReady=1` continuously; pulses spaced 2 clk → each transfer `evCount=1`, no lost events, total count equals pulses sent.
- **Reset mid-operation:** 2 pulses pending under stall; assert `rstn=0` asynchronously mid-cycle → `evValid`, `evCount`, `overflow` immediately 0. Release; one pulse → `evCount=1`.

Source files
------------

// File: rtl/fin_sync.sv
// fin_sync: captures rising edges of an asynchronous completion pulse, synchronizes
// them into clk and presents coalesced, saturating event counts over valid/ready.
module fin_sync #(
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 fin,
    output logic                 evValid,
    input  logic                 evReady,
    output logic [CNT_WIDTH-1:0] evCount,
    output logic                 overflow,
    input  logic                 clrOverflow
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Capture: toggle on every fin rising edge, so pulses narrower than clk survive
    logic fin_tgl_q;
    logic fin_tgl_d;

    always_comb begin
        fin_tgl_d = ~fin_tgl_q;
    end

    always_ff @(posedge fin or negedge rstn) begin
        if (!rstn) begin
            fin_tgl_q <= 1'b0;
        end else begin
            fin_tgl_q <= fin_tgl_d;
        end
    end

    // Synchronizer chain plus one history flop for edge detection
    logic [SYNC_STAGES-1:0] s_q;
    logic [SYNC_STAGES-1:0] s_d;
    logic                   p_q;
    logic                   p_d;
    logic                   evt;

    always_comb begin
        s_d = {s_q[SYNC_STAGES-2:0], fin_tgl_q};
        p_d = s_q[SYNC_STAGES-1];
        evt = s_q[SYNC_STAGES-1] ^ p_q;
    end

    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] acc_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 ovf_q;
    logic                 ovf_d;

    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] sum_sat;
    logic                 ovf_set;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            s_q     <= '0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            s_q     <= s_d;
            p_q     <= p_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        sum     = {1'b0, acc_q} + {{CNT_WIDTH{1'b0}}, evt};
        sum_sat = sum[CNT_WIDTH] ? CNT_MAX : sum[CNT_WIDTH-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (evt) begin
                    cnt_d   = CNT_ONE;
                    acc_d   = '0;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // An evt arriving with acc already at max is lost, whether or not accepted
                ovf_set = evt && (acc_q == CNT_MAX);
                if (evReady) begin
                    if (sum != '0) begin
                        cnt_d = sum_sat;
                        acc_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (evt && (acc_q != CNT_MAX)) begin
                    acc_d = acc_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ovf_d = ovf_set | (ovf_q & ~clrOverflow);
    end

    // Outputs
    always_comb begin
        evValid  = (state_q == ST_VALID);
        evCount  = cnt_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_fin_sync.sv
// Directed bench for fin_sync: default instance plus a CNT_WIDTH=2 instance for saturation.
module tb_fin_sync;

    logic       clk = 1'b0;
    logic       rstn;
    logic       fin;
    logic       ready_a, clr_a, valid_a, ovf_a;
    logic [3:0] cnt_a;
    logic       ready_b, clr_b, valid_b, ovf_b;
    logic [1:0] cnt_b;

    int checks   = 0;
    int failures = 0;
    int tot_a    = 0;
    int xfer_a   = 0;
    int base_tot;
    int base_xfer;

    always #5 clk = ~clk;

    fin_sync #(.CNT_WIDTH(4), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rstn(rstn), .fin(fin),
        .evValid(valid_a), .evReady(ready_a), .evCount(cnt_a),
        .overflow(ovf_a), .clrOverflow(clr_a)
    );

    fin_sync #(.CNT_WIDTH(2), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rstn(rstn), .fin(fin),
        .evValid(valid_b), .evReady(ready_b), .evCount(cnt_b),
        .overflow(ovf_b), .clrOverflow(clr_b)
    );

    // Handshake inputs only change at posedge+1, so negedge sees the upcoming accept
    always @(negedge clk) begin
        if (rstn && valid_a && ready_a) begin
            tot_a  += int'(cnt_a);
            xfer_a += 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input int dly, input int w);
        #(dly) fin = 1'b1;
        #(w)   fin = 1'b0;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        clr_a   = 1'b0;
        clr_b   = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        rstn = 1'b0; fin = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_ovf", 32'(ovf_a), 0);
        chk("rst_valid_b", 32'(valid_b), 0);
        repeat (2) step();
        rstn = 1'b1;
        step();

        // Single 3 ns event, accepted immediately
        ready_a = 1'b1;
        fire(1, 3);
        step(); step();
        chk("single_early", 32'(valid_a), 0);
        step();
        chk("single_valid", 32'(valid_a), 1);
        chk("single_count", 32'(cnt_a), 1);
        step();
        chk("single_drop", 32'(valid_a), 0);
        chk("single_ovf", 32'(ovf_a), 0);

        // Narrow 1 ns pulse mid-cycle
        fire(4, 1);
        step(); step(); step();
        chk("narrow_valid", 32'(valid_a), 1);
        chk("narrow_count", 32'(cnt_a), 1);
        step();
        chk("narrow_drop", 32'(valid_a), 0);

        // evt on the same edge as accept must reload, not drop
        ready_a = 1'b0;
        fire(1, 3);
        step(); step(); step();
        chk("coll_first", 32'(valid_a), 1);
        fire(1, 3);
        step(); step();
        ready_a = 1'b1;
        step();
        chk("coll_reload_valid", 32'(valid_a), 1);
        chk("coll_reload_count", 32'(cnt_a), 1);
        step();
        chk("coll_idle", 32'(valid_a), 0);

        // Coalescing under stall
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fire(1, 3);
            step(); step(); step();
            chk("coal_hold_valid", 32'(valid_a), 1);
            chk("coal_hold_count", 32'(cnt_a), 1);
        end
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
        chk("coal_second_valid", 32'(valid_a), 1);
        chk("coal_second_count", 32'(cnt_a), 3);
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
        chk("coal_idle", 32'(valid_a), 0);
        chk("coal_ovf", 32'(ovf_a), 0);

        // Saturation on the 2-bit instance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fire(1, 3);
            step(); step(); step();
            chk("sat_hold_count", 32'(cnt_b), 1);
            if (i == 3) chk("sat_no_ovf_yet", 32'(ovf_b), 0);
            if (i == 4) chk("sat_ovf_set", 32'(ovf_b), 1);
        end
        ready_b = 1'b1;
        step();
        ready_b = 1'b0;
        chk("sat_second_valid", 32'(valid_b), 1);
        chk("sat_second_count", 32'(cnt_b), 3);
        chk("sat_ovf_sticky", 32'(ovf_b), 1);
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        chk("sat_ovf_clear", 32'(ovf_b), 0);
        for (int i = 0; i < 3; i++) begin
            fire(1, 3);
            step(); step(); step();
        end
        chk("sat_refill_no_ovf", 32'(ovf_b), 0);
        fire(1, 3);
        step(); step();
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        chk("sat_set_wins", 32'(ovf_b), 1);
        chk("sat_count_stable", 32'(cnt_b), 3);

        // Streaming with evReady held high, pulses 2 clk apart
        do_reset();
        ready_a   = 1'b1;
        base_tot  = tot_a;
        base_xfer = xfer_a;
        for (int i = 0; i < 6; i++) begin
            fire(1, 3);
            step(); step();
        end
        repeat (5) step();
        chk("stream_total", 32'(tot_a - base_tot), 6);
        chk("stream_xfers", 32'(xfer_a - base_xfer), 6);
        chk("stream_idle", 32'(valid_a), 0);
        ready_a = 1'b0;

        // Reset mid-operation, including an edge still in the synchronizer
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fire(1, 3);
            step(); step(); step();
        end
        chk("mid_pre_valid", 32'(valid_a), 1);
        chk("mid_pre_ovf_b", 32'(ovf_b), 1);
        fire(1, 3);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_a), 0);
        chk("mid_rst_count", 32'(cnt_a), 0);
        chk("mid_rst_ovf_b", 32'(ovf_b), 0);
        step();
        rstn = 1'b1;
        repeat (5) step();
        chk("mid_no_stale", 32'(valid_a), 0);
        fire(1, 3);
        step(); step(); step();
        chk("mid_post_valid", 32'(valid_a), 1);
        chk("mid_post_count", 32'(cnt_a), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
